// File: rtl/qinj_pulse_gen.sv
// ============================================================================
//  Module   : qinj_pulse_gen
//  Purpose  : Charge-injection pulse/burst generator for the pixel-matrix
//             H-tree (ChargeInj_IN). Turns a one-cycle fast command into a
//             programmable delayed pulse or pulse burst in 40 MHz BX units,
//             and keeps injection / missed-command counters for readback.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module qinj_pulse_gen #(
  parameter int DLY_W = 5,   // width of coarseDelay and burstGap
  parameter int WID_W = 4,   // width of pulseWidth and burstNum
  parameter int CNT_W = 8    // width of injCount and missedCount
) (
  input  logic             CLK40,
  input  logic             RSTn,
  input  logic             QInjEn,
  input  logic             QInjCmd,
  input  logic [DLY_W-1:0] coarseDelay,
  input  logic [WID_W-1:0] pulseWidth,
  input  logic [WID_W-1:0] burstNum,
  input  logic [DLY_W-1:0] burstGap,
  output logic             ChargeInj,
  output logic             busy,
  output logic [CNT_W-1:0] injCount,
  output logic [CNT_W-1:0] missedCount
);

  // --------------------------------------------------------------------------
  // State encoding. DELAY also serves as the "pulse pending" state when the
  // captured coarse delay is zero: its counter is already 0 on entry, so the
  // pulse starts on the very next edge.
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic [DLY_W-1:0] dly_cnt_q,   dly_cnt_d;    // remaining delay cycles
  logic [WID_W-1:0] wid_cnt_q,   wid_cnt_d;    // remaining high cycles - 1
  logic [DLY_W-1:0] gap_cnt_q,   gap_cnt_d;    // remaining low cycles - 1
  logic [WID_W-1:0] burst_cnt_q, burst_cnt_d;  // pulses still to issue after this one
  logic [WID_W-1:0] wid_cfg_q,   wid_cfg_d;    // captured max(pulseWidth,1) - 1
  logic [DLY_W-1:0] gap_cfg_q,   gap_cfg_d;    // captured max(burstGap,1) - 1
  logic             inj_q,       inj_d;
  logic             busy_q,      busy_d;
  logic [CNT_W-1:0] inj_cnt_q,   inj_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q,  miss_cnt_d;

  // --------------------------------------------------------------------------
  // Command qualification and zero-to-one field normalisation
  // --------------------------------------------------------------------------
  logic             cmd_valid;
  logic             cmd_accept;
  logic             cmd_missed;
  logic [WID_W-1:0] wid_m1;
  logic [WID_W-1:0] burst_m1;
  logic [DLY_W-1:0] gap_m1;
  logic             inj_rise;
  logic             miss_sat;

  assign cmd_valid  = QInjCmd & QInjEn;
  assign cmd_accept = cmd_valid & (state_q == S_IDLE);
  assign cmd_missed = cmd_valid & (state_q != S_IDLE);

  // A zero field behaves as one, so "minus one" of zero stays zero.
  assign wid_m1   = (pulseWidth == '0) ? '0 : pulseWidth - WID_W'(1);
  assign burst_m1 = (burstNum   == '0) ? '0 : burstNum   - WID_W'(1);
  assign gap_m1   = (burstGap   == '0) ? '0 : burstGap   - DLY_W'(1);

  // --------------------------------------------------------------------------
  // Pulse sequencing FSM: next state, pulse and busy outputs, timing counters
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    wid_cnt_d   = wid_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_cnt_d = burst_cnt_q;
    wid_cfg_d   = wid_cfg_q;
    gap_cfg_d   = gap_cfg_q;
    inj_d       = inj_q;
    busy_d      = busy_q;

    if (!QInjEn) begin
      // Disable aborts any command in progress on the next edge.
      state_d = S_IDLE;
      inj_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_accept) begin
            // Capture the whole configuration at accept time; later changes
            // on the inputs do not disturb the running command.
            state_d     = S_DELAY;
            busy_d      = 1'b1;
            dly_cnt_d   = coarseDelay;
            wid_cfg_d   = wid_m1;
            gap_cfg_d   = gap_m1;
            burst_cnt_d = burst_m1;
          end
        end

        S_DELAY: begin
          if (dly_cnt_q == '0) begin
            state_d   = S_PULSE;
            inj_d     = 1'b1;
            wid_cnt_d = wid_cfg_q;
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
          end
        end

        S_PULSE: begin
          if (wid_cnt_q == '0) begin
            inj_d = 1'b0;
            if (burst_cnt_q != '0) begin
              state_d     = S_GAP;
              gap_cnt_d   = gap_cfg_q;
              burst_cnt_d = burst_cnt_q - WID_W'(1);
            end else begin
              // Last pulse of the burst: pulse and busy drop together and
              // the FSM is ready for a new command on the following edge.
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            wid_cnt_d = wid_cnt_q - WID_W'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_d   = S_PULSE;
            inj_d     = 1'b1;
            wid_cnt_d = wid_cfg_q;
          end else begin
            gap_cnt_d = gap_cnt_q - DLY_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          inj_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Readback counters: injCount wraps, missedCount saturates. Both only move
  // on events that require QInjEn=1, so they hold while the block is disabled.
  // --------------------------------------------------------------------------
  assign inj_rise = inj_d & ~inj_q;
  assign miss_sat = &miss_cnt_q;

  // Counter next-state: count pulse rising edges and dropped commands
  always_comb begin
    inj_cnt_d  = inj_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (inj_rise) begin
      inj_cnt_d = inj_cnt_q + CNT_W'(1);
    end
    if (cmd_missed && !miss_sat) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // State and output registers; reset clears the pulse asynchronously
  always_ff @(posedge CLK40 or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      dly_cnt_q   <= '0;
      wid_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      burst_cnt_q <= '0;
      wid_cfg_q   <= '0;
      gap_cfg_q   <= '0;
      inj_q       <= 1'b0;
      busy_q      <= 1'b0;
      inj_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      wid_cnt_q   <= wid_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      wid_cfg_q   <= wid_cfg_d;
      gap_cfg_q   <= gap_cfg_d;
      inj_q       <= inj_d;
      busy_q      <= busy_d;
      inj_cnt_q   <= inj_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers
  // --------------------------------------------------------------------------
  assign ChargeInj   = inj_q;
  assign busy        = busy_q;
  assign injCount    = inj_cnt_q;
  assign missedCount = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_qinj_pulse_gen.sv
// ============================================================================
//  Module   : tb_qinj_pulse_gen
//  Purpose  : Self-checking bench for qinj_pulse_gen: vector tables for the
//             single-shot cases, hand sequences for burst/busy/enable/limit
//             corners, and randomized traffic against a schedule-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_qinj_pulse_gen;

  logic       CLK40;
  logic       RSTn;
  logic       QInjEn;
  logic       QInjCmd;
  logic [4:0] coarseDelay;
  logic [3:0] pulseWidth;
  logic [3:0] burstNum;
  logic [4:0] burstGap;
  logic       ChargeInj;
  logic       busy;
  logic [7:0] injCount;
  logic [7:0] missedCount;

  int n_total = 0;
  int n_pass  = 0;

  qinj_pulse_gen #(.DLY_W(5), .WID_W(4), .CNT_W(8)) dut (
    .CLK40       (CLK40),
    .RSTn        (RSTn),
    .QInjEn      (QInjEn),
    .QInjCmd     (QInjCmd),
    .coarseDelay (coarseDelay),
    .pulseWidth  (pulseWidth),
    .burstNum    (burstNum),
    .burstGap    (burstGap),
    .ChargeInj   (ChargeInj),
    .busy        (busy),
    .injCount    (injCount),
    .missedCount (missedCount)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: on accept it records the captured fields and the accept
  // edge; the waveform at any later edge is computed arithmetically from the
  // pulse schedule (first rise at acc+1+D, period W+G, B pulses).
  // --------------------------------------------------------------------------
  int t_now;
  bit m_active, m_inj, m_busy;
  int m_acc, m_D, m_W, m_B, m_G;
  int m_injcnt, m_miss;

  task automatic model_reset();
    m_active = 0; m_inj = 0; m_busy = 0;
    m_injcnt = 0; m_miss = 0;
  endtask

  task automatic model_edge(input bit en, input bit cmd, input int d, input int w,
                            input int b, input int g);
    bit prev_busy, prev_inj;
    int per, endt, off;
    prev_busy = m_busy;
    prev_inj  = m_inj;
    t_now++;
    if (!en) m_active = 0;
    else if (cmd) begin
      if (!prev_busy) begin
        m_active = 1; m_acc = t_now; m_D = d;
        m_W = (w == 0) ? 1 : w;
        m_B = (b == 0) ? 1 : b;
        m_G = (g == 0) ? 1 : g;
      end else if (m_miss < 255) m_miss++;
    end
    m_inj = 0; m_busy = 0;
    if (m_active) begin
      per  = m_W + m_G;
      endt = m_acc + 1 + m_D + m_B * per - m_G;
      if (t_now >= endt) m_active = 0;
      else begin
        m_busy = 1;
        off = t_now - (m_acc + 1 + m_D);
        if (off >= 0 && (off % per) < m_W) m_inj = 1;
      end
    end
    if (m_inj && !prev_inj) m_injcnt = (m_injcnt + 1) % 256;
  endtask

  // One clock: drive inputs at negedge, sample #1 after posedge, compare model
  task automatic step(input bit en, input bit cmd);
    @(negedge CLK40);
    QInjEn  = en;
    QInjCmd = cmd;
    @(posedge CLK40);
    #1;
    model_edge(en, cmd, int'(coarseDelay), int'(pulseWidth), int'(burstNum), int'(burstGap));
    check("model_ChargeInj", ChargeInj, m_inj);
    check("model_busy", busy, m_busy);
    check("model_injCount", injCount, m_injcnt);
    check("model_missedCount", missedCount, m_miss);
  endtask

  task automatic set_fields(input int d, input int w, input int b, input int g);
    coarseDelay = 5'(d); pulseWidth = 4'(w); burstNum = 4'(b); burstGap = 5'(g);
  endtask

  task automatic async_reset();
    RSTn = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK40);
    RSTn = 1'b1;
  endtask

  typedef struct {
    logic en;
    logic cmd;
    logic exp_ci;
    logic exp_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic run_table(input string name);
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].en, tbl[k].cmd);
      check({name, "_ChargeInj"}, ChargeInj, tbl[k].exp_ci);
      check({name, "_busy"}, busy, tbl[k].exp_busy);
    end
  endtask

  int base_inj, base_miss;

  initial begin
    RSTn = 1'b0; QInjEn = 1'b1; QInjCmd = 1'b0;
    set_fields(0, 0, 0, 0);
    t_now = 0;
    model_reset();
    #12;
    check("reset_ChargeInj", ChargeInj, 0);
    check("reset_busy", busy, 0);
    check("reset_injCount", injCount, 0);
    check("reset_missedCount", missedCount, 0);
    @(negedge CLK40);
    RSTn = 1'b1;

    // ---- Reset mid-pulse: pulse must drop without waiting for a clock ----
    set_fields(0, 8, 1, 1);
    step(1, 1);
    step(1, 0);
    step(1, 0);
    check("midpulse_high", ChargeInj, 1);
    #2;
    RSTn = 1'b0;
    model_reset();
    #1;
    check("async_rst_ChargeInj", ChargeInj, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_injCount", injCount, 0);
    check("async_rst_missedCount", missedCount, 0);
    repeat (2) @(negedge CLK40);
    RSTn = 1'b1;

    // ---- Single shot D=3 W=2 B=1, command at edge 10 ----
    set_fields(3, 2, 1, 1);
    tbl.delete();
    for (int k = 1; k <= 18; k++)
      tbl.push_back('{1'b1, k == 10, (k == 14 || k == 15), (k >= 10 && k <= 15)});
    run_table("single");
    check("single_injCount", injCount, 1);

    // ---- Zero fields: one-cycle pulse right after accept ----
    set_fields(0, 0, 0, 0);
    tbl.delete();
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{1'b1, k == 5, k == 6, (k == 5 || k == 6)});
    run_table("zero");
    check("zero_injCount", injCount, 2);

    // ---- Burst D=1 W=3 B=4 G=2, accept at rel edge 0 ----
    set_fields(1, 3, 4, 2);
    base_inj = int'(injCount);
    for (int r = 0; r <= 21; r++) begin
      step(1, r == 0);
      check("burst_ChargeInj", ChargeInj,
            (r inside {[2:4], [7:9], [12:14], [17:19]}) ? 1 : 0);
      check("burst_busy", busy, (r <= 19) ? 1 : 0);
    end
    check("burst_injCount", injCount, 8'(base_inj + 4));

    // ---- Commands while busy (edge 8 and last pulse cycle), then re-accept ----
    base_inj  = int'(injCount);
    base_miss = int'(missedCount);
    for (int r = 0; r <= 21; r++) begin
      step(1, r inside {0, 8, 19, 21});
      check("busycmd_ChargeInj", ChargeInj,
            (r inside {[2:4], [7:9], [12:14], [17:19]}) ? 1 : 0);
      check("busycmd_busy", busy, (r <= 19 || r == 21) ? 1 : 0);
    end
    check("busycmd_missed", missedCount, 8'(base_miss + 2));
    check("busycmd_injCount", injCount, 8'(base_inj + 4));
    for (int r = 0; r < 24; r++) step(1, 0);
    check("reaccept_injCount", injCount, 8'(base_inj + 8));

    // ---- Enable deasserted mid-burst; command with enable low ignored ----
    set_fields(5, 3, 4, 2);
    base_inj  = int'(injCount);
    base_miss = int'(missedCount);
    for (int r = 0; r <= 14; r++) begin
      step(r <= 9, (r == 0) || (r == 12));
      if (r == 6) check("enable_first_rise", ChargeInj, 1);
      if (r >= 10) begin
        check("enable_off_ChargeInj", ChargeInj, 0);
        check("enable_off_busy", busy, 0);
      end
    end
    check("enable_missed_hold", missedCount, 8'(base_miss));
    check("enable_injCount", injCount, 8'(base_inj + 1));
    step(1, 0);

    // ---- Counter limits: 300 missed commands saturate at 255 ----
    async_reset();
    set_fields(31, 15, 15, 31);
    step(1, 1);
    for (int i = 0; i < 300; i++) step(1, 1);
    check("missed_saturate", missedCount, 255);
    step(0, 0);
    step(1, 0);

    // ---- 256 single pulses wrap injCount back to 0 ----
    async_reset();
    set_fields(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(1, 1);
      step(1, 0);
      step(1, 0);
      if (i == 254) check("injCount_255", injCount, 255);
    end
    check("injCount_wrap", injCount, 0);

    // ---- Randomized traffic against the model, fields change every cycle ----
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_fields($urandom_range(0, 31), $urandom_range(0, 15),
                   $urandom_range(0, 3), $urandom_range(0, 31));
      else
        set_fields($urandom_range(0, 6), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4));
      step($urandom_range(0, 31) != 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
